// File: rtl/dual_bit_serializer.sv
// Serializes a pair of WIDTH-bit words onto w1/w2, one bit pair per clock.
// Frames are flagged with bit_valid/last_bit, may run back to back, and can be stalled with shift_en.
module dual_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_word,
    input  logic [WIDTH-1:0] b_word,
    input  logic             shift_en,
    output logic             w1,
    output logic             w2,
    output logic             bit_valid,
    output logic             last_bit
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;
    logic [CW-1:0]    r_cnt;
    logic             w_load;
    logic             w_adv;
    logic             w_done;

    function automatic logic first_bit(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    function automatic logic [WIDTH-1:0] drop_bit(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? (v << 1) : (v >> 1);
    endfunction

    // NOTE: every signal driven here gets a default first, so no path through the block can infer a latch.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        w_adv        = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE:  in_ready = 1'b1;
            SHIFT: begin
                if (shift_en) begin
                    if (last_bit) in_ready = 1'b1;
                    else          w_adv    = 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase
        if (reset) in_ready = 1'b0;
        w_load = in_valid && in_ready;
        if (!w_load && r_state == SHIFT && shift_en && last_bit) w_done = 1'b1;
        if (w_load)      w_next_state = SHIFT;
        else if (w_done) w_next_state = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // The word pair shows its first bit straight from the inputs; the shift registers keep only the remainder.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sh_a    <= '0;
            r_sh_b    <= '0;
            r_cnt     <= '0;
            w1        <= 1'b0;
            w2        <= 1'b0;
            bit_valid <= 1'b0;
            last_bit  <= 1'b0;
        end else if (w_load) begin
            r_sh_a    <= drop_bit(a_word);
            r_sh_b    <= drop_bit(b_word);
            r_cnt     <= '0;
            w1        <= first_bit(a_word);
            w2        <= first_bit(b_word);
            bit_valid <= 1'b1;
            last_bit  <= 1'b0;
        end else if (w_adv) begin
            r_sh_a    <= drop_bit(r_sh_a);
            r_sh_b    <= drop_bit(r_sh_b);
            r_cnt     <= r_cnt + CW'(1);
            w1        <= first_bit(r_sh_a);
            w2        <= first_bit(r_sh_b);
            last_bit  <= ((r_cnt + CW'(1)) == LAST_IDX);
        end else if (w_done) begin
            r_sh_a    <= '0;
            r_sh_b    <= '0;
            r_cnt     <= '0;
            w1        <= 1'b0;
            w2        <= 1'b0;
            bit_valid <= 1'b0;
            last_bit  <= 1'b0;
        end
    end

endmodule
